// File: rtl/uart_cmd_host_pkg.sv
// rtl/uart_cmd_host_pkg.sv - shared widths, frame opcodes, op and FSM encodings
package uart_cmd_host_pkg;

  localparam int DATA_WIDTH = 8;

  localparam logic [7:0] OPC_RF_WR   = 8'hAA;
  localparam logic [7:0] OPC_RF_RD   = 8'hBB;
  localparam logic [7:0] OPC_ALU_OP  = 8'hCC;
  localparam logic [7:0] OPC_ALU_NOP = 8'hDD;

  typedef logic [1:0] op_t;
  localparam op_t OP_RF_WR   = 2'd0;
  localparam op_t OP_RF_RD   = 2'd1;
  localparam op_t OP_ALU_OP  = 2'd2;
  localparam op_t OP_ALU_NOP = 2'd3;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_TX_START = 3'd1;
  localparam logic [2:0] S_TX_DATA  = 3'd2;
  localparam logic [2:0] S_TX_STOP  = 3'd3;
  localparam logic [2:0] S_WAIT_RSP = 3'd4;
  localparam logic [2:0] S_RX_DATA  = 3'd5;
  localparam logic [2:0] S_RX_STOP  = 3'd6;
  localparam logic [2:0] S_DONE     = 3'd7;

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_START = 2'd1;
  localparam logic [1:0] R_DATA  = 2'd2;
  localparam logic [1:0] R_STOP  = 2'd3;

  function automatic logic [2:0] frame_bytes(input op_t op);
    case (op)
      OP_RF_WR:  return 3'd3;
      OP_RF_RD:  return 3'd2;
      OP_ALU_OP: return 3'd4;
      default:   return 3'd2;
    endcase
  endfunction

endpackage

// File: rtl/uart_host_rx.sv
// rtl/uart_host_rx.sv - response receiver: rx synchroniser, mid-bit sampler, shift register
module uart_host_rx
  import uart_cmd_host_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_rx,
  input  logic [15:0]      i_baud_div,
  output logic             o_busy,
  output logic             o_stop,
  output logic             o_valid,
  output logic             o_err,
  output logic [WIDTH-1:0] o_data
);

  localparam int BW = $clog2(WIDTH);

  logic [1:0]       phase;
  logic [15:0]      cnt;
  logic [BW-1:0]    bit_idx;
  logic             s1, s2, s3;
  logic [15:0]      half_m1;
  logic             bit_end;

  assign half_m1 = {1'b0, i_baud_div[15:1]} - 16'd1;
  assign bit_end = (cnt == i_baud_div - 16'd1);
  assign o_busy  = (phase != R_IDLE);
  assign o_stop  = (phase == R_STOP);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      phase   <= R_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      s1      <= 1'b1;
      s2      <= 1'b1;
      s3      <= 1'b1;
      o_valid <= 1'b0;
      o_err   <= 1'b0;
      o_data  <= '0;
    end else begin
      s1      <= i_rx;
      s2      <= s1;
      s3      <= s2;
      o_valid <= 1'b0;
      o_err   <= 1'b0;
      if (!i_en) begin
        phase <= R_IDLE;
        cnt   <= '0;
      end else begin
        case (phase)
          R_IDLE: if (s3 && !s2) begin
            phase <= R_START;
            cnt   <= '0;
          end
          // a start that is high again at mid-bit was only a glitch
          R_START: if (cnt == half_m1) begin
            cnt     <= '0;
            bit_idx <= '0;
            phase   <= s2 ? R_IDLE : R_DATA;
          end else begin
            cnt <= cnt + 16'd1;
          end
          R_DATA: if (bit_end) begin
            cnt    <= '0;
            o_data <= {s2, o_data[WIDTH-1:1]};
            if (bit_idx == BW'(WIDTH - 1)) phase <= R_STOP;
            else bit_idx <= bit_idx + BW'(1);
          end else begin
            cnt <= cnt + 16'd1;
          end
          default: if (bit_end) begin
            cnt     <= '0;
            phase   <= R_IDLE;
            o_valid <= s2;
            o_err   <= !s2;
          end else begin
            cnt <= cnt + 16'd1;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/uart_cmd_host.sv
// rtl/uart_cmd_host.sv - command host: frames commands onto a UART line and waits for the reply byte
module uart_cmd_host
  import uart_cmd_host_pkg::*;
#(
  parameter int WIDTH        = DATA_WIDTH,
  parameter int TIMEOUT_BITS = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [15:0]      i_baud_div,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [1:0]       i_cmd_op,
  input  logic [WIDTH-1:0] i_addr,
  input  logic [WIDTH-1:0] i_data,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  input  logic [WIDTH-1:0] i_func,
  output logic             o_tx,
  input  logic             i_rx,
  output logic             o_rsp_valid,
  output logic [WIDTH-1:0] o_rsp_data,
  output logic             o_done,
  output logic             o_timeout,
  output logic             o_rsp_err
);

  localparam int BW = $clog2(WIDTH);
  localparam int TW = 16 + $clog2(TIMEOUT_BITS) + 1;

  logic [2:0]       state;
  logic [15:0]      baud_q;
  op_t              op_q;
  logic [WIDTH-1:0] sh, f0, f1, f2;
  logic [2:0]       bytes_left;
  logic [15:0]      bit_cnt;
  logic [BW-1:0]    bit_idx;
  logic [TW-1:0]    tcnt, tmo_lim;
  logic             bit_end;
  logic             rx_en, rx_busy, rx_stop, rx_valid, rx_err;
  logic [WIDTH-1:0] rx_data;

  assign bit_end     = (bit_cnt == baud_q - 16'd1);
  assign tmo_lim     = TW'(baud_q) * TW'(TIMEOUT_BITS);
  assign o_cmd_ready = (state == S_IDLE);
  assign o_done      = (state == S_DONE);
  assign rx_en       = (state == S_WAIT_RSP) || (state == S_RX_DATA) || (state == S_RX_STOP);

  always_comb begin
    o_tx = 1'b1;
    if (state == S_TX_START) o_tx = 1'b0;
    else if (state == S_TX_DATA) o_tx = sh[0];
  end

  uart_host_rx #(.WIDTH(WIDTH)) u_rx (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_en       (rx_en),
    .i_rx       (i_rx),
    .i_baud_div (baud_q),
    .o_busy     (rx_busy),
    .o_stop     (rx_stop),
    .o_valid    (rx_valid),
    .o_err      (rx_err),
    .o_data     (rx_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_IDLE;
      baud_q      <= '0;
      op_q        <= OP_RF_WR;
      sh          <= '0;
      f0          <= '0;
      f1          <= '0;
      f2          <= '0;
      bytes_left  <= '0;
      bit_cnt     <= '0;
      bit_idx     <= '0;
      tcnt        <= '0;
      o_rsp_data  <= '0;
      o_rsp_valid <= 1'b0;
      o_timeout   <= 1'b0;
      o_rsp_err   <= 1'b0;
    end else begin
      o_rsp_valid <= 1'b0;
      o_timeout   <= 1'b0;
      o_rsp_err   <= 1'b0;
      case (state)
        S_IDLE: if (i_cmd_valid) begin
          baud_q     <= i_baud_div;
          op_q       <= i_cmd_op;
          bytes_left <= frame_bytes(i_cmd_op) - 3'd1;
          bit_cnt    <= '0;
          state      <= S_TX_START;
          // sh holds the byte on the wire; f0..f2 queue the rest of the frame
          case (i_cmd_op)
            OP_RF_WR:  begin sh <= WIDTH'(OPC_RF_WR);  f0 <= i_addr; f1 <= i_data; f2 <= '0;     end
            OP_RF_RD:  begin sh <= WIDTH'(OPC_RF_RD);  f0 <= i_addr; f1 <= '0;     f2 <= '0;     end
            OP_ALU_OP: begin sh <= WIDTH'(OPC_ALU_OP); f0 <= i_op_a; f1 <= i_op_b; f2 <= i_func; end
            default:   begin sh <= WIDTH'(OPC_ALU_NOP); f0 <= i_func; f1 <= '0;    f2 <= '0;     end
          endcase
        end
        S_TX_START: if (bit_end) begin
          bit_cnt <= '0;
          bit_idx <= '0;
          state   <= S_TX_DATA;
        end else begin
          bit_cnt <= bit_cnt + 16'd1;
        end
        S_TX_DATA: if (bit_end) begin
          bit_cnt <= '0;
          sh      <= sh >> 1;
          if (bit_idx == BW'(WIDTH - 1)) state <= S_TX_STOP;
          else bit_idx <= bit_idx + BW'(1);
        end else begin
          bit_cnt <= bit_cnt + 16'd1;
        end
        S_TX_STOP: if (bit_end) begin
          bit_cnt <= '0;
          if (bytes_left != 3'd0) begin
            sh         <= f0;
            f0         <= f1;
            f1         <= f2;
            f2         <= '0;
            bytes_left <= bytes_left - 3'd1;
            state      <= S_TX_START;
          end else if (op_q == OP_RF_WR) begin
            state <= S_DONE;
          end else begin
            tcnt  <= '0;
            state <= S_WAIT_RSP;
          end
        end else begin
          bit_cnt <= bit_cnt + 16'd1;
        end
        S_WAIT_RSP: if (rx_busy) begin
          state <= S_RX_DATA;
        end else if (tcnt == tmo_lim - TW'(1)) begin
          o_timeout <= 1'b1;
          state     <= S_DONE;
        end else begin
          tcnt <= tcnt + TW'(1);
        end
        S_RX_DATA: if (rx_stop) begin
          state <= S_RX_STOP;
        end else if (!rx_busy) begin
          tcnt  <= '0;
          state <= S_WAIT_RSP;
        end
        S_RX_STOP: if (o_rsp_valid) begin
          state <= S_DONE;
        end else if (rx_valid) begin
          o_rsp_data  <= rx_data;
          o_rsp_valid <= 1'b1;
        end else if (rx_err) begin
          o_rsp_err <= 1'b1;
          state     <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_cmd_host.md
UART_CMD_HOST -- requirements
Module: uart_cmd_host

Interface
REQ-001 Parameter WIDTH, default 8, byte width of all data fields.
REQ-002 Parameter TIMEOUT_BITS, default 64, response wait limit in bit periods.
REQ-003 i_clk  in  1  single clock; all logic rising-edge.
REQ-004 i_rst  in  1  reset, synchronous, active-high.
REQ-005 i_baud_div  in  16  clock cycles per UART bit; legal values ≥4; captured at command accept.
REQ-006 i_cmd_valid  in  1  command request.
REQ-007 o_cmd_ready  out  1  host idle; can accept a command.
REQ-008 i_cmd_op  in  2  operation: 0 RF_WR, 1 RF_RD, 2 ALU_OP, 3 ALU_NOP.
REQ-009 i_addr, i_data, i_op_a, i_op_b  in  WIDTH each  command fields.
REQ-010 i_func  in  WIDTH  ALU function byte.
REQ-011 o_tx  out  1  serial line to the processing unit's rx.
REQ-012 i_rx  in  1  serial line from the processing unit's tx.
REQ-013 o_rsp_valid  out  1  one-cycle pulse; o_rsp_data holds the response byte.
REQ-014 o_rsp_data  out  WIDTH  last received response byte; held until the next response.
REQ-015 o_done  out  1  one-cycle pulse when a command completes, with or without an error.
REQ-016 o_timeout, o_rsp_err  out  1 each  one-cycle pulses, coincident with o_done.

Function
REQ-017 Handshake: a command is accepted on a cycle where i_cmd_valid and o_cmd_ready are both high; all fields are captured on that cycle.
REQ-018 o_cmd_ready is high only in IDLE; i_cmd_valid is ignored when o_cmd_ready is low.
REQ-019 Frames, in this byte order:
  - RF_WR: 0xAA, addr, data.
  - RF_RD: 0xBB, addr.
  - ALU_OP: 0xCC, A, B, func.
  - ALU_NOP: 0xDD, func.
REQ-020 Serial format is 8N1:
  - idle high;
  - start bit 0;
  - 8 data bits, LSB first;
  - one stop bit 1.
REQ-021 Every bit lasts exactly the captured i_baud_div cycles.
REQ-022 The start bit of byte 0 drives o_tx low on the first cycle after accept.
REQ-023 Bytes are sent back-to-back; a stop bit is followed immediately by the next start bit.
REQ-024 FSM states: IDLE, TX_START, TX_DATA, TX_STOP, WAIT_RSP, RX_DATA, RX_STOP, DONE.
  - TX_STOP → TX_START when bytes remain.
  - TX_STOP → DONE when last byte sent and op is RF_WR.
  - TX_STOP → WAIT_RSP otherwise.
  - DONE → IDLE after one cycle.
REQ-025 o_done asserts in DONE; RF_WR completes 10×bytes×i_baud_div cycles after accept.
REQ-026 In WAIT_RSP, a 1→0 transition on i_rx, sampled on a 2-flop synchronised copy, starts reception.
REQ-027 The start bit is re-checked at i_baud_div/2 cycles; if i_rx is high, the event is a glitch and the FSM returns to WAIT_RSP.
REQ-028 Data bits are sampled at the middle of each bit period.
REQ-029 Stop bit sampled mid-bit:
  - 1: o_rsp_data updates and o_rsp_valid pulses one cycle later.
  - 0: o_rsp_err pulses and o_rsp_data is unchanged.
  - Either case → DONE.
REQ-030 If no start bit is detected within TIMEOUT_BITS×i_baud_div cycles of entering WAIT_RSP, o_timeout pulses → DONE.
REQ-031 i_rx activity outside WAIT_RSP/RX_* is ignored.
REQ-032 o_tx is 1 in every state except TX_START, and except TX_DATA when transmitting a 0 bit.
REQ-033 Bit and timeout counters are free of overflow at i_baud_div = 0xFFFF: timeout counter width ≥ 16 + clog2(TIMEOUT_BITS) + 1.

Reset
REQ-034 On i_rst: state IDLE, o_tx=1, o_cmd_ready=1, o_rsp_data=0, all pulses 0, counters 0.
REQ-035 Reset mid-frame aborts the command: o_tx is 1 from the next edge, and no o_done is produced.

Structure
REQ-036 Frame opcodes (0xAA/0xBB/0xCC/0xDD), op encodings and the FSM state encoding live in the shared parameters include, next to WIDTH.
REQ-037 The receive path (synchroniser, mid-bit sampler, shift register) is sub-module uart_host_rx, with enable/valid/err outputs. The FSM and TX serializer remain in uart_cmd_host.

Verification
REQ-038 i_baud_div=16, RF_WR addr 0x05 data 0x3C → o_tx carries 0xAA, 0x05, 0x3C; o_done at cycle 480 after accept; no o_rsp_valid.
REQ-039 RF_RD addr 0x05; bench model replies 0x5A after 3 bit idle → o_rsp_valid with o_rsp_data=0x5A, then o_done the cycle after.
REQ-040 ALU_OP A=0x07 B=0x03 func=0x00 → 40 bit frame (0xCC, 0x07, 0x03, 0x00); model reply 0x0A received correctly.
REQ-041 RF_RD with silent i_rx, i_baud_div=8 → o_timeout and o_done exactly 512 cycles after entering WAIT_RSP.
REQ-042 Reply with stop bit 0 → o_rsp_err; o_rsp_data keeps its previous value. A 3-cycle low glitch on i_rx is ignored.
REQ-043 Assert i_rst during byte 1 of RF_WR → o_tx=1 next cycle, o_cmd_ready=1, no o_done; the next command runs normally.
